mac_accum: RTL and testbench



---
 rtl/mac_accum_pkg.sv | 11 +
 rtl/mac_accum_wallace.sv | 17 +
 rtl/mac_accum.sv | 98 +++++++++
 tb/tb_mac_accum.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_accum_pkg.sv
// Shared types and widths for the streaming multiply-accumulate unit.
package mac_accum_pkg;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FLUSH = 2'd1,
    OUT   = 2'd2
  } state_e;
endpackage

// File: rtl/mac_accum_wallace.sv
// 8x8 unsigned combinational multiplier; partial products reduced into one sum.
module Wallace (
  input  logic [7:0]  ina,
  input  logic [7:0]  inb,
  output logic [15:0] result_out
);
  logic [15:0] pp [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = inb[i] ? (16'(ina) << i) : 16'd0;
    end
  end

  assign result_out = ((pp[0] + pp[1]) + (pp[2] + pp[3])) +
                      ((pp[4] + pp[5]) + (pp[6] + pp[7]));
endmodule

// File: rtl/mac_accum.sv
// Streaming multiply-accumulate: 3-stage pipeline (operands, product, accumulate)
// summing products per frame, with a valid/ready result port.
module mac_accum
  import mac_accum_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  state_e              state, state_nx;
  logic [2:1]          vld_pipe, last_pipe;
  logic [OP_W-1:0]     op_a, op_b;
  logic [PROD_W-1:0]   mul, prod;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt, cnt_inc;
  logic                ovf;
  logic [ACC_W:0]      sum;
  logic                accept, close;

  assign in_ready = (state == ACC) && rst_n;
  assign accept   = in_valid && in_ready;
  assign close    = vld_pipe[2] && last_pipe[2];
  // Extra top bit of the sum is the carry that feeds the sticky overflow.
  assign sum      = {1'b0, acc} + (ACC_W+1)'(prod);
  assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;

  Wallace u_mul (
    .ina        (op_a),
    .inb        (op_b),
    .result_out (mul)
  );

  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    case (state)
      ACC:   if (accept && in_last) state_nx = FLUSH;
      FLUSH: if (close) state_nx = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ACC;
      end
      default: state_nx = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACC;
      vld_pipe  <= '0;
      last_pipe <= '0;
      op_a      <= '0;
      op_b      <= '0;
      prod      <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state     <= state_nx;
      vld_pipe  <= {vld_pipe[1], accept};
      last_pipe <= {last_pipe[1], accept && in_last};
      if (accept) begin
        op_a <= in_a;
        op_b <= in_b;
      end
      if (vld_pipe[1]) prod <= mul;
      if (vld_pipe[2]) begin
        if (last_pipe[2]) begin
          out_acc   <= sum[ACC_W-1:0];
          out_count <= cnt_inc;
          out_ovf   <= ovf | sum[ACC_W];
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
        end else begin
          acc <= sum[ACC_W-1:0];
          cnt <= cnt_inc;
          ovf <= ovf | sum[ACC_W];
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: frame-level reference model checked every cycle,
// directed frames with hand-computed results, then randomized frames.
module tb_mac_accum;
  localparam int ACC_W = 20;
  localparam int CNT_W = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0] in_a = 8'd0, in_b = 8'd0;
  wire in_ready, out_valid, out_ovf;
  wire [ACC_W-1:0] out_acc;
  wire [CNT_W-1:0] out_count;

  always #5 clk = ~clk;

  mac_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count),
    .out_ovf(out_ovf)
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int acc; int cnt; int ovf; int due; } res_t;
  res_t  q[$];
  longint m_sum = 0;
  int    m_n = 0;
  bit    busy = 0, chk_rst = 0, rr_en = 0;
  int    pops = 0, last_acc_cyc = 0;
  int    got_acc[$], got_cnt[$], got_ovf[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: a frame result is the plain sum of its products, reported 3 cycles
  // after the last beat is accepted; no new beats until that result is consumed.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      begin
        bit ev, er;
        res_t r;
        ev = (q.size() > 0) && (cyc >= q[0].due);
        er = rst_n && !busy;
        chk("in_ready", in_ready, er);
        chk("out_valid", out_valid, ev);
        if (chk_rst) begin
          chk("rst_acc", out_acc, 0);
          chk("rst_count", out_count, 0);
          chk("rst_ovf", out_ovf, 0);
          chk_rst = 0;
        end
        if (ev) begin
          chk("out_acc", out_acc, q[0].acc);
          chk("out_count", out_count, q[0].cnt);
          chk("out_ovf", out_ovf, q[0].ovf);
        end
        if (!rst_n) begin
          q.delete();
          busy = 0; m_sum = 0; m_n = 0; chk_rst = 1;
        end else begin
          if (in_valid && er) begin
            m_sum += longint'(in_a) * longint'(in_b);
            m_n++;
            last_acc_cyc = cyc;
            if (in_last) begin
              r.acc = int'(m_sum % (longint'(1) << ACC_W));
              r.cnt = (m_n > 255) ? 255 : m_n;
              r.ovf = (m_sum >= (longint'(1) << ACC_W)) ? 1 : 0;
              r.due = cyc + 3;
              q.push_back(r);
              busy = 1; m_sum = 0; m_n = 0;
            end
          end
          if (ev && out_ready) begin
            got_acc.push_back(int'(out_acc));
            got_cnt.push_back(int'(out_count));
            got_ovf.push_back(int'(out_ovf));
            pops++;
            void'(q.pop_front());
            busy = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input bit last);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'($urandom_range(0, 1));
        in_a = 8'($urandom); in_b = 8'($urandom);
        return;
      end
    end
    chk("beat_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_pop(input int target);
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk);
      if (pops >= target) begin #1; return; end
    end
    chk("pop_timeout", pops, target);
    #1;
  endtask

  initial begin
    int p0, c1, len;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;

    // 3-beat frame
    p0 = pops;
    beat(3, 4, 0); beat(10, 20, 0); beat(255, 255, 1);
    wait_pop(p0 + 1);
    chk("f3_acc", got_acc[$], 65237);
    chk("f3_cnt", got_cnt[$], 3);
    chk("f3_ovf", got_ovf[$], 0);

    // 16 and 17 full-scale beats
    p0 = pops;
    for (int i = 0; i < 16; i++) beat(255, 255, i == 15);
    wait_pop(p0 + 1);
    chk("f16_acc", got_acc[$], 1040400);
    chk("f16_ovf", got_ovf[$], 0);
    p0 = pops;
    for (int i = 0; i < 17; i++) beat(255, 255, i == 16);
    wait_pop(p0 + 1);
    chk("f17_acc", got_acc[$], 56849);
    chk("f17_cnt", got_cnt[$], 17);
    chk("f17_ovf", got_ovf[$], 1);

    // back-to-back single-beat frames
    p0 = pops;
    beat(0, 123, 1); c1 = last_acc_cyc;
    beat(2, 3, 1);
    chk("single_spacing", last_acc_cyc - c1, 4);
    wait_pop(p0 + 2);
    chk("single0_acc", got_acc[p0], 0);
    chk("single1_acc", got_acc[p0 + 1], 6);

    // backpressure with blocked input pulses
    p0 = pops;
    out_ready = 1'b0;
    beat(20, 10, 1);
    for (int t = 0; t < 20 && !out_valid; t++) idle(1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_last = 1'b1;
      idle(1);
      chk("bp_ready_low", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_pop(p0 + 1);
    chk("bp_acc", got_acc[$], 200);
    chk("bp_cnt", got_cnt[$], 1);

    // gaps mid-frame
    p0 = pops;
    beat(1, 1, 0); idle(2); beat(2, 2, 0); idle(1); beat(3, 3, 1);
    wait_pop(p0 + 1);
    chk("gap_acc", got_acc[$], 14);
    chk("gap_cnt", got_cnt[$], 3);

    // reset while flushing discards the frame
    p0 = pops;
    beat(1, 1, 0); beat(2, 2, 1);
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    idle(4);
    chk("rst_no_result", pops, p0);
    beat(5, 5, 1);
    wait_pop(p0 + 1);
    chk("post_rst_acc", got_acc[$], 25);
    chk("post_rst_ovf", got_ovf[$], 0);

    // counter saturation
    p0 = pops;
    for (int i = 0; i < 260; i++) beat(1, 1, i == 259);
    wait_pop(p0 + 1);
    chk("sat_acc", got_acc[$], 260);
    chk("sat_cnt", got_cnt[$], 255);

    // randomized frames with random gaps and random backpressure
    p0 = pops;
    rr_en = 1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        if (f % 4 == 0) beat(8'($urandom_range(200, 255)), 8'($urandom_range(200, 255)), i == len - 1);
        else beat(8'($urandom), 8'($urandom), i == len - 1);
      end
    end
    wait_pop(p0 + 40);
    rr_en = 0; out_ready = 1'b1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
